// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_fetch_unit_pkg;

    localparam int          FETCH_XLEN    = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;   // addi x0,x0,0

    // BOOT: idle cycle after reset; FETCH: request on the bus;
    // WAIT: request accepted, awaiting data; HOLD: data parked in skid while
    // decode is stalled; DRAIN: stale response still in flight after a redirect.
    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_skid_buffer.sv
// One-entry holding register for an instruction word that arrived while decode was stalled.
// Latency: loaded word visible one cycle after i_load.
// Backpressure: none; the owner only loads when empty, clear wins over load.
module pc_fetch_unit_skid_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat,
    output logic         o_vld
);

    logic [W-1:0] r_dat;
    logic         r_vld;

    // Capture the parked word; a clear (redirect) discards it.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_dat <= '0;
            r_vld <= 1'b0;
        end else if (i_clear) begin
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_dat <= i_dat;
            r_vld <= 1'b1;
        end
    end

    assign o_dat = r_dat;
    assign o_vld = r_vld;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, imem req/ready + valid handshake, IF/ID register with stall/flush/redirect.
// Latency: IF/ID valid one cycle after imemValid; request re-issued the cycle after delivery.
// Backpressure: stallD holds IF/ID and parks a returning word in the skid; no new request until it drains.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              XLEN      = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEF)
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            pcSrcE,
    input  logic [XLEN-1:0] pcTargetE,
    input  logic            stallD,
    input  logic            flushD,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemReady,
    input  logic            imemValid,
    input  logic [XLEN-1:0] imemRdata,
    output logic [XLEN-1:0] instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcPlus4D,
    output logic            validD,
    output logic            misalignErr
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_imem_req;
    logic [XLEN-1:0] r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc_plus4_d;
    logic            r_valid_d;
    logic            r_misalign;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target_aligned;
    logic            w_skid_load;
    logic            w_skid_vld;
    logic [XLEN-1:0] w_skid_dat;
    logic            w_load_mem;
    logic            w_load_skid;
    logic            w_advance;
    logic [XLEN-1:0] w_load_dat;

    // Wraps modulo 2^XLEN by construction.
    assign w_pc_plus4       = r_pc + XLEN'(4);
    assign w_target_aligned = {pcTargetE[XLEN-1:2], 2'b00};

    // A word arriving while decode is stalled is parked rather than dropped.
    assign w_skid_load = !pcSrcE && (r_state == ST_WAIT) && imemValid && stallD;

    // Delivery into IF/ID: directly from memory, or from the skid once the stall lifts.
    assign w_load_mem  = !pcSrcE && (r_state == ST_WAIT) && imemValid && !stallD;
    assign w_load_skid = !pcSrcE && (r_state == ST_HOLD) && !stallD && w_skid_vld;
    assign w_advance   = w_load_mem || w_load_skid;
    assign w_load_dat  = w_load_skid ? w_skid_dat : imemRdata;

    pc_fetch_unit_skid_buffer #(
        .W (XLEN)
    ) u_skid (
        .clk     (clk),
        .rstN    (rstN),
        .i_load  (w_skid_load),
        .i_clear (pcSrcE),
        .i_dat   (imemRdata),
        .o_dat   (w_skid_dat),
        .o_vld   (w_skid_vld)
    );

    // Fetch FSM with PC register and registered request; redirect overrides everything.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_imem_req <= 1'b0;
        end else if (pcSrcE) begin
            r_pc <= w_target_aligned;
            case (r_state)
                ST_WAIT: begin
                    // Without the response this cycle it is still owed and must be drained.
                    if (imemValid) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end else begin
                        r_state    <= ST_DRAIN;
                        r_imem_req <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // A request accepted this cycle is now stale.
                    if (imemReady) begin
                        r_state    <= ST_DRAIN;
                        r_imem_req <= 1'b0;
                    end else begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (imemValid) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end else begin
                        r_state    <= ST_DRAIN;
                        r_imem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                end
            endcase
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imemReady) begin
                        r_state    <= ST_WAIT;
                        r_imem_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imemValid) begin
                        if (!stallD) begin
                            r_pc       <= w_pc_plus4;
                            r_state    <= ST_FETCH;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_load_skid) begin
                        r_pc       <= w_pc_plus4;
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (imemValid) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_BOOT;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: invalidate on redirect/flush, load on delivery, hold on stall, else bubble.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (pcSrcE || flushD) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (w_advance) begin
            r_instr_d    <= w_load_dat;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
        end else if (!stallD) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end
    end

    // One-cycle flag for a redirect target that was not word aligned.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= pcSrcE && (pcTargetE[1:0] != 2'b00);
        end
    end

    assign imemReq     = r_imem_req;
    assign imemAddr    = r_pc;
    assign instrD      = r_instr_d;
    assign pcD         = r_pc_d;
    assign pcPlus4D    = r_pc_plus4_d;
    assign validD      = r_valid_d;
    assign misalignErr = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for the fetch stage against a transaction-level reference model.
// Latency: memory answers 1-3 cycles after acceptance, in order.
// Backpressure: random imemReady, stallD, flushD, redirects and occasional resets.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN, pcSrcE, stallD, flushD;
    logic        imemReq, imemReady, imemValid, validD, misalignErr;
    logic [31:0] pcTargetE, imemAddr, imemRdata, instrD, pcD, pcPlus4D;

    pc_fetch_unit dut (
        .clk         (clk),
        .rstN        (rstN),
        .pcSrcE      (pcSrcE),
        .pcTargetE   (pcTargetE),
        .stallD      (stallD),
        .flushD      (flushD),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemReady   (imemReady),
        .imemValid   (imemValid),
        .imemRdata   (imemRdata),
        .instrD      (instrD),
        .pcD         (pcD),
        .pcPlus4D    (pcPlus4D),
        .validD      (validD),
        .misalignErr (misalignErr)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } mreq_t;

    mreq_t       mem_q[$];      // accepted requests awaiting a response, in order
    logic [31:0] dlv_q[$];      // responses received but not yet in IF/ID
    logic [31:0] next_pc;       // address the next accepted request must carry
    logic [31:0] cur_pc;        // PC of the entry the model says IF/ID holds
    logic [31:0] last_tgt;
    bit          m_vld;
    bit          last_reset, last_redir, last_acc, stray, do_rst;
    int          cyc, last_due, n_dlv, n_wrap, n_mis;
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Compare DUT outputs with what the model predicts after the edge just passed.
    task automatic check_outputs();
        if (last_reset) begin
            check("rst_req",      imemReq,     1'b0);
            check("rst_addr",     imemAddr,    32'h0);
            check("rst_validD",   validD,      1'b0);
            check("rst_instrD",   instrD,      NOP);
            check("rst_pcD",      pcD,         32'h0);
            check("rst_pcPlus4D", pcPlus4D,    32'h0);
            check("rst_misalign", misalignErr, 1'b0);
        end else begin
            check("misalign", misalignErr, last_redir && (last_tgt[1:0] != 2'b00));
            check("validD", validD, m_vld);
            if (m_vld) begin
                check("pcD",      pcD,      cur_pc);
                check("instrD",   instrD,   mem_word(cur_pc));
                check("pcPlus4D", pcPlus4D, cur_pc + 32'd4);
            end else begin
                check("instrD_nop", instrD, NOP);
            end
            if (last_acc) check("req_after_accept", imemReq, 1'b0);
            if (imemReq)  check("addr_aligned", imemAddr[1:0], 2'b00);
        end
    endtask

    // Choose inputs for the coming edge; the memory side follows its response queue.
    task automatic drive_inputs(input bit quiet);
        stray  = last_reset;
        do_rst = !quiet && ($urandom_range(0, 299) == 0);
        rstN   = !do_rst;
        if (stray) begin
            // A late response after reset: the DUT is in BOOT and must ignore it.
            imemValid = 1'b1;
            imemRdata = $urandom;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imemValid = 1'b1;
            imemRdata = mem_word(mem_q[0].addr);
        end else begin
            imemValid = 1'b0;
            imemRdata = $urandom;
        end
        imemReady = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
        stallD    = quiet ? 1'b0 : ($urandom_range(0, 9) < 3);
        pcSrcE    = quiet ? 1'b0 : ($urandom_range(0, 24) == 0);
        flushD    = quiet ? 1'b0 : (pcSrcE ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0));
        case ($urandom_range(0, 4))
            0:       pcTargetE = 32'h0000_0100;
            1:       pcTargetE = 32'h0000_0102;
            2:       pcTargetE = 32'hFFFF_FFF8;
            3:       pcTargetE = 32'hFFFF_FFFB;
            default: pcTargetE = $urandom;
        endcase
    endtask

    // Advance the reference model across the coming edge.
    task automatic model_update();
        bit acc;
        mreq_t m;
        if (do_rst) begin
            mem_q.delete();
            dlv_q.delete();
            next_pc    = 32'h0;
            m_vld      = 1'b0;
            last_reset = 1'b1;
            last_redir = 1'b0;
            last_acc   = 1'b0;
            last_due   = 0;
        end else begin
            last_reset = 1'b0;
            acc = imemReq && imemReady;
            if (acc) begin
                check("req_addr", imemAddr, next_pc);
                m.addr   = next_pc;
                m.due    = cyc + 1 + $urandom_range(0, 2);
                if (m.due <= last_due) m.due = last_due + 1;
                last_due = m.due;
                m.live   = 1'b1;
                mem_q.push_back(m);
                next_pc  = next_pc + 32'd4;
            end
            if (imemValid && !stray && mem_q.size() > 0) begin
                m = mem_q.pop_front();
                if (m.live) dlv_q.push_back(m.addr);
            end
            if (pcSrcE) begin
                foreach (mem_q[i]) mem_q[i].live = 1'b0;
                dlv_q.delete();
                next_pc = pcTargetE & 32'hFFFF_FFFC;
                m_vld   = 1'b0;
                if (pcTargetE[1:0] != 2'b00) n_mis++;
            end else if (flushD) begin
                // Flush invalidates IF/ID; an unstalled delivery is consumed and lost.
                if (!stallD && dlv_q.size() > 0) void'(dlv_q.pop_front());
                m_vld = 1'b0;
            end else if (!stallD) begin
                if (dlv_q.size() > 0) begin
                    cur_pc = dlv_q.pop_front();
                    m_vld  = 1'b1;
                    n_dlv++;
                    if (cur_pc == 32'hFFFF_FFFC) n_wrap++;
                end else begin
                    m_vld = 1'b0;
                end
            end
            last_acc   = acc;
            last_redir = pcSrcE;
            last_tgt   = pcTargetE;
        end
    endtask

    task automatic one_cycle(input bit quiet);
        check_outputs();
        drive_inputs(quiet);
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        cyc = 0; n_dlv = 0; n_wrap = 0; n_mis = 0; last_due = 0;
        pcSrcE = 1'b0; pcTargetE = '0; stallD = 1'b0; flushD = 1'b0;
        imemReady = 1'b0; imemValid = 1'b0; imemRdata = '0;
        stray = 1'b0; last_tgt = '0; cur_pc = '0;
        do_rst = 1'b1;
        rstN   = 1'b0;
        model_update();
        @(negedge clk);

        for (int i = 0; i < 4000; i++) one_cycle(1'b0);
        for (int i = 0; i < 30; i++)   one_cycle(1'b1);

        check_outputs();
        check("dlv_backlog", dlv_q.size() <= 1, 1'b1);
        check("deliveries",  n_dlv >= 100,       1'b1);
        check("wrap_seen",   n_wrap > 0,         1'b1);
        check("misalign_seen", n_mis > 0,        1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
